mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_port_arbiter_rr_select.sv | 33 +++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port definitions: 2-bit operation encodings, arbiter states, data width.
// Imported by the arbiter and its round-robin selector.
`ifndef TYPE_BW
`define TYPE_BW 16
`endif

package mem_port_arbiter_pkg;

    localparam int TYPE_BW = `TYPE_BW;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_READ  = 2'b01;
    localparam logic [1:0] MEM_OP_WRITE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        TURN = 2'b10
    } arb_state_t;

    // 2'b10 is illegal and deliberately counts as "not requesting".
    function automatic logic op_is_request(input logic [1:0] op);
        return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Combinational round-robin pick: first requester after i_last in circular order.
// Zero latency; o_vld low when nobody requests.
module mem_port_arbiter_rr_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_REQ-1:0] o_oh,
    output logic [IW-1:0]      o_idx,
    output logic               o_vld
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_oh   = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IW'((int'(i_last) + k) % NUM_REQ);
            if (!o_vld && i_req[w_cand]) begin
                o_vld        = 1'b1;
                o_idx        = w_cand;
                o_oh[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one memory port: IDLE -> BUSY (until opdone/watchdog) -> TURN.
// Request to mem_operation 1 cycle; opdone to req_opdone 1 cycle; one transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [32*NUM_REQ-1:0]      req_addr,
    input  logic [TYPE_BW*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         req_opdone,
    output logic [TYPE_BW-1:0]         req_rdata,
    output logic [1:0]                 mem_operation,
    output logic [31:0]                addr_o,
    output logic [TYPE_BW-1:0]         data_o,
    input  logic                       mem_opdone,
    input  logic [TYPE_BW-1:0]         data_i,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       timeout_err
);

    localparam int            IW      = idx_width(NUM_REQ);
    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    arb_state_t    r_state;
    logic [IW-1:0] r_last_grant;
    logic [IW-1:0] r_gidx;
    logic [CW-1:0] r_wd_cnt;

    logic [1:0]         w_op    [NUM_REQ];
    logic [31:0]        w_addr  [NUM_REQ];
    logic [TYPE_BW-1:0] w_wdata [NUM_REQ];
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_sel_oh;
    logic [IW-1:0]      w_sel_idx;
    logic               w_sel_vld;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_op[g]    = req_op[2*g +: 2];
        assign w_addr[g]  = req_addr[32*g +: 32];
        assign w_wdata[g] = req_wdata[TYPE_BW*g +: TYPE_BW];
        assign w_req[g]   = op_is_request(w_op[g]);

        a_legal_op: assert property (@(posedge clk) disable iff (!reset) w_op[g] != 2'b10);
    end

    mem_port_arbiter_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_select (
        .i_req  (w_req),
        .i_last (r_last_grant),
        .o_oh   (w_sel_oh),
        .o_idx  (w_sel_idx),
        .o_vld  (w_sel_vld)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_last_grant  <= IW'(NUM_REQ - 1);
            r_gidx        <= '0;
            r_wd_cnt      <= '0;
            req_opdone    <= '0;
            req_rdata     <= '0;
            mem_operation <= MEM_OP_NONE;
            addr_o        <= '0;
            data_o        <= '0;
            grant         <= '0;
            timeout_err   <= 1'b0;
        end else begin
            req_opdone  <= '0;
            timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sel_vld) begin
                        mem_operation <= w_op[w_sel_idx];
                        addr_o        <= w_addr[w_sel_idx];
                        data_o        <= w_wdata[w_sel_idx];
                        grant         <= w_sel_oh;
                        r_gidx        <= w_sel_idx;
                        r_wd_cnt      <= '0;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_opdone) begin
                        req_opdone    <= grant;
                        req_rdata     <= data_i;
                        r_last_grant  <= r_gidx;
                        mem_operation <= MEM_OP_NONE;
                        grant         <= '0;
                        r_state       <= TURN;
                    end else if ((TIMEOUT != 0) && (r_wd_cnt == WD_LAST)) begin
                        // Abort: the master still gets its completion so it never hangs.
                        timeout_err   <= 1'b1;
                        req_opdone    <= grant;
                        req_rdata     <= '0;
                        r_last_grant  <= r_gidx;
                        mem_operation <= MEM_OP_NONE;
                        grant         <= '0;
                        r_state       <= TURN;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                TURN:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a behavioural memory and an expected-completion queue.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int TO = 8;
    localparam int W  = TYPE_BW;

    logic              clk        = 1'b0;
    logic              reset      = 1'b0;
    logic [2*NR-1:0]   req_op     = '0;
    logic [32*NR-1:0]  req_addr   = '0;
    logic [W*NR-1:0]   req_wdata  = '0;
    logic              mem_opdone = 1'b0;
    logic [W-1:0]      data_i     = '0;
    logic [NR-1:0]     req_opdone;
    logic [W-1:0]      req_rdata;
    logic [1:0]        mem_operation;
    logic [31:0]       addr_o;
    logic [W-1:0]      data_o;
    logic [NR-1:0]     grant;
    logic              timeout_err;

    int vectors     = 0;
    int miscompares = 0;
    bit mem_auto    = 1'b0;
    bit late_done   = 1'b0;
    int mem_lat     = 3;
    int mem_cnt     = 0;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [W-1:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    mem_port_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_opdone    (req_opdone),
        .req_rdata     (req_rdata),
        .mem_operation (mem_operation),
        .addr_o        (addr_o),
        .data_o        (data_o),
        .mem_opdone    (mem_opdone),
        .data_i        (data_i),
        .grant         (grant),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mem_data(input logic [31:0] a);
        return (a == 32'h10) ? W'(16'hABCD) : W'(32'h1000 ^ a);
    endfunction

    // Memory: answers mem_lat cycles into an access; late_done forces a stray completion.
    initial begin
        forever begin
            @(negedge clk);
            mem_opdone = 1'b0;
            if (mem_auto && mem_operation != MEM_OP_NONE) begin
                if (mem_cnt == mem_lat) begin
                    mem_opdone = 1'b1;
                    data_i     = mem_data(addr_o);
                    mem_cnt    = 0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
            if (late_done) begin
                mem_opdone = 1'b1;
                data_i     = W'(16'hDEAD);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [1:0] op, input logic [31:0] a, input logic [W-1:0] d);
        req_op[2*m +: 2]   = op;
        req_addr[32*m +: 32] = a;
        req_wdata[W*m +: W]  = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({mem_operation, grant, req_opdone, timeout_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: op=%b grant=%b opdone=%b to=%b, expected all 0", mem_operation, grant, req_opdone, timeout_err);
        end
        vectors++;
        if ({addr_o, data_o, req_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h data=%h rdata=%h, expected all 0", addr_o, data_o, req_rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_contention();
        exp_t e;
        int done;
        logic [1:0] prev_op;
        for (int i = 0; i < 4; i++) begin
            e.m     = i % 2;
            e.addr  = (i % 2 == 1) ? 32'h200 : 32'h100;
            e.rdata = mem_data(e.addr);
            exp_q.push_back(e);
        end
        mem_lat  = 2;
        mem_auto = 1'b1;
        set_req(0, MEM_OP_READ, 32'h100, '0);
        set_req(1, MEM_OP_READ, 32'h200, '0);
        tick();
        vectors++;
        if (mem_operation !== MEM_OP_READ || grant !== 2'b01 || addr_o !== 32'h100) begin
            miscompares++;
            $display("FAIL cont_first: op=%b grant=%b addr=%h, expected op=01 grant=01 addr=00000100", mem_operation, grant, addr_o);
        end
        done    = 0;
        prev_op = mem_operation;
        for (int c = 0; c < 100 && done < 4; c++) begin
            tick();
            if (mem_operation != MEM_OP_NONE && prev_op == MEM_OP_NONE) begin
                vectors++;
                if (exp_q.size() == 0 || grant !== NR'(1 << exp_q[0].m) || addr_o !== exp_q[0].addr) begin
                    miscompares++;
                    $display("FAIL cont_issue: grant=%b addr=%h, expected master %0d", grant, addr_o, (exp_q.size() > 0) ? exp_q[0].m : -1);
                end
            end
            if (req_opdone != '0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL cont_done: unexpected opdone=%b", req_opdone);
                end else begin
                    e = exp_q.pop_front();
                    if (req_opdone !== NR'(1 << e.m) || req_rdata !== e.rdata) begin
                        miscompares++;
                        $display("FAIL cont_done: opdone=%b rdata=%h, expected master %0d rdata=%h", req_opdone, req_rdata, e.m, e.rdata);
                    end
                end
                done++;
                if (done == 4) req_op = '0;
            end
            prev_op = mem_operation;
        end
        vectors++;
        if (done != 4) begin
            miscompares++;
            $display("FAIL cont_count: %0d completions, expected 4", done);
        end
        exp_q.delete();
    endtask

    task automatic test_single_read();
        exp_t e;
        int n;
        repeat (3) tick();
        mem_lat  = 3;
        mem_auto = 1'b1;
        e.m = 1; e.addr = 32'h10; e.rdata = W'(16'hABCD);
        exp_q.push_back(e);
        set_req(1, MEM_OP_READ, 32'h10, '0);
        tick();
        vectors++;
        if (mem_operation !== MEM_OP_READ || addr_o !== 32'h10 || grant !== 2'b10) begin
            miscompares++;
            $display("FAIL single_issue: op=%b addr=%h grant=%b, expected op=01 addr=00000010 grant=10", mem_operation, addr_o, grant);
        end
        n = 0;
        while (n < 20 && req_opdone == '0) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 4 || mem_opdone !== 1'b1) begin
            miscompares++;
            $display("FAIL single_latency: done after %0d cycles (prev opdone=%b), expected 4 cycles after prev opdone=1", n, mem_opdone);
        end
        e = exp_q.pop_front();
        vectors++;
        if (req_opdone !== 2'b10 || req_rdata !== e.rdata || mem_operation !== MEM_OP_NONE) begin
            miscompares++;
            $display("FAIL single_done: opdone=%b rdata=%h op=%b, expected opdone=10 rdata=%h op=00", req_opdone, req_rdata, mem_operation, e.rdata);
        end
        set_req(1, MEM_OP_NONE, 32'h0, '0);
    endtask

    task automatic test_streaming();
        exp_t e;
        int issues, dones;
        logic [1:0] prev_op;
        repeat (3) tick();
        mem_lat  = 1;
        mem_auto = 1'b1;
        for (int a = 0; a < 5; a++) begin
            e.m = 1; e.addr = 32'(a); e.rdata = mem_data(32'(a));
            exp_q.push_back(e);
        end
        set_req(1, MEM_OP_READ, 32'h0, '0);
        issues  = 0;
        dones   = 0;
        prev_op = mem_operation;
        for (int c = 0; c < 200 && dones < 5; c++) begin
            tick();
            if (mem_operation != MEM_OP_NONE && prev_op == MEM_OP_NONE) begin
                issues++;
                vectors++;
                if (exp_q.size() == 0 || addr_o !== exp_q[0].addr || grant !== 2'b10) begin
                    miscompares++;
                    $display("FAIL stream_issue: addr=%h grant=%b, expected addr=%h grant=10", addr_o, grant, (exp_q.size() > 0) ? exp_q[0].addr : 32'hFFFF_FFFF);
                end
            end
            if (req_opdone != '0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_done: unexpected opdone=%b", req_opdone);
                end else begin
                    e = exp_q.pop_front();
                    if (req_opdone !== 2'b10 || req_rdata !== e.rdata || mem_operation !== MEM_OP_NONE) begin
                        miscompares++;
                        $display("FAIL stream_done: opdone=%b rdata=%h op=%b, expected 10 %h 00", req_opdone, req_rdata, mem_operation, e.rdata);
                    end
                end
                dones++;
                if (dones < 5) set_req(1, MEM_OP_READ, 32'(dones), '0);
                else           set_req(1, MEM_OP_NONE, 32'h0, '0);
            end
            prev_op = mem_operation;
        end
        vectors++;
        if (issues != 5 || dones != 5) begin
            miscompares++;
            $display("FAIL stream_count: issues=%0d dones=%0d, expected 5 and 5", issues, dones);
        end
        exp_q.delete();
    endtask

    task automatic test_write();
        int n;
        repeat (3) tick();
        mem_lat  = 3;
        mem_auto = 1'b1;
        set_req(0, MEM_OP_WRITE, 32'h20, W'(5));
        tick();
        vectors++;
        if (mem_operation !== MEM_OP_WRITE || addr_o !== 32'h20 || data_o !== W'(5) || grant !== 2'b01) begin
            miscompares++;
            $display("FAIL write_issue: op=%b addr=%h data=%h grant=%b, expected 11 00000020 5 01", mem_operation, addr_o, data_o, grant);
        end
        set_req(0, MEM_OP_WRITE, 32'h24, W'(7));
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (req_opdone != '0) break;
            vectors++;
            if (data_o !== W'(5) || addr_o !== 32'h20 || mem_operation !== MEM_OP_WRITE) begin
                miscompares++;
                $display("FAIL write_hold: data=%h addr=%h op=%b, expected 5 00000020 11", data_o, addr_o, mem_operation);
            end
        end
        vectors++;
        if (req_opdone !== 2'b01) begin
            miscompares++;
            $display("FAIL write_done: opdone=%b, expected 01", req_opdone);
        end
        set_req(0, MEM_OP_NONE, 32'h0, '0);
    endtask

    task automatic test_watchdog();
        int el;
        repeat (3) tick();
        mem_auto = 1'b0;
        set_req(0, MEM_OP_READ, 32'h30, '0);
        tick();
        vectors++;
        if (grant !== 2'b01 || mem_operation !== MEM_OP_READ) begin
            miscompares++;
            $display("FAIL wd_issue: grant=%b op=%b, expected 01 01", grant, mem_operation);
        end
        el = 0;
        while (el < 20 && timeout_err !== 1'b1) begin
            tick();
            el++;
        end
        vectors++;
        if (el != TO || req_opdone !== 2'b01 || req_rdata !== '0) begin
            miscompares++;
            $display("FAIL wd_fire: after %0d cycles opdone=%b rdata=%h, expected %0d cycles opdone=01 rdata=0", el, req_opdone, req_rdata, TO);
        end
        set_req(0, MEM_OP_NONE, 32'h0, '0);
        late_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (req_opdone !== '0 || grant !== '0 || mem_operation !== MEM_OP_NONE || timeout_err !== 1'b0) begin
                miscompares++;
                $display("FAIL wd_late: opdone=%b grant=%b op=%b to=%b, expected all 0", req_opdone, grant, mem_operation, timeout_err);
            end
        end
        late_done = 1'b0;
        mem_auto  = 1'b1;
        mem_lat   = 1;
        set_req(1, MEM_OP_READ, 32'h50, '0);
        tick();
        vectors++;
        if (grant !== 2'b10 || addr_o !== 32'h50) begin
            miscompares++;
            $display("FAIL wd_recover: grant=%b addr=%h, expected 10 00000050", grant, addr_o);
        end
        el = 0;
        while (el < 20 && req_opdone == '0) begin
            tick();
            el++;
        end
        vectors++;
        if (req_opdone !== 2'b10 || req_rdata !== mem_data(32'h50)) begin
            miscompares++;
            $display("FAIL wd_recover_done: opdone=%b rdata=%h, expected 10 %h", req_opdone, req_rdata, mem_data(32'h50));
        end
        set_req(1, MEM_OP_NONE, 32'h0, '0);
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (3) tick();
        mem_auto = 1'b1;
        mem_lat  = 1;
        set_req(0, MEM_OP_READ, 32'h60, '0);
        tick();
        n = 0;
        while (n < 20 && req_opdone == '0) begin
            tick();
            n++;
        end
        vectors++;
        if (req_opdone !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_pre: opdone=%b, expected 01", req_opdone);
        end
        set_req(0, MEM_OP_NONE, 32'h0, '0);
        repeat (2) tick();
        mem_auto = 1'b0;
        set_req(1, MEM_OP_READ, 32'h90, '0);
        tick();
        tick();
        vectors++;
        if (grant !== 2'b10 || mem_operation !== MEM_OP_READ) begin
            miscompares++;
            $display("FAIL rst_busy: grant=%b op=%b, expected 10 01", grant, mem_operation);
        end
        reset     = 1'b0;
        late_done = 1'b1;
        #1;
        vectors++;
        if (mem_operation !== MEM_OP_NONE || grant !== '0 || req_opdone !== '0) begin
            miscompares++;
            $display("FAIL rst_async: op=%b grant=%b opdone=%b, expected all 0", mem_operation, grant, req_opdone);
        end
        tick();
        tick();
        req_op = '0;
        reset  = 1'b1;
        tick();
        vectors++;
        if (req_opdone !== '0 || grant !== '0) begin
            miscompares++;
            $display("FAIL rst_late_done: opdone=%b grant=%b, expected 0 0", req_opdone, grant);
        end
        late_done = 1'b0;
        set_req(0, MEM_OP_READ, 32'h70, '0);
        set_req(1, MEM_OP_READ, 32'h80, '0);
        tick();
        vectors++;
        if (grant !== 2'b01 || addr_o !== 32'h70) begin
            miscompares++;
            $display("FAIL rst_restart: grant=%b addr=%h, expected 01 00000070", grant, addr_o);
        end
        mem_auto = 1'b1;
        n = 0;
        while (n < 20 && req_opdone == '0) begin
            tick();
            n++;
        end
        vectors++;
        if (req_opdone !== 2'b01 || req_rdata !== mem_data(32'h70)) begin
            miscompares++;
            $display("FAIL rst_restart_done: opdone=%b rdata=%h, expected 01 %h", req_opdone, req_rdata, mem_data(32'h70));
        end
        req_op = '0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_streaming();
        test_write();
        test_watchdog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
